// File: rtl/bus_timer3_pkg.sv
// Shared definitions for the three-channel bus timer: mode encodings,
// channel count and control-register field positions.
package bus_timer3_pkg;

  typedef enum logic [1:0] {
    ONESHOT = 2'b00,
    RATE    = 2'b01,
    SQUARE  = 2'b10,
    HOLD    = 2'b11
  } mode_e;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned SEL_LSB  = 0;
  localparam int unsigned SEL_MSB  = 1;
  localparam int unsigned MODE_LSB = 2;
  localparam int unsigned MODE_MSB = 3;
  localparam int unsigned EN_BIT   = 4;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: 32-bit down-counter with reload, mode and enable,
// producing a one-shot, rate or square-wave output level.
module timer_channel
  import bus_timer3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic        cfg_we,
  input  mode_e       cfg_mode,
  input  logic        cfg_en,
  output logic [31:0] count,
  output logic        out
);

  logic [31:0] reload;
  mode_e       mode;
  logic        en;
  mode_e       eff_mode;
  logic [31:0] count_nx;
  logic        out_nx;

  // A load wins over a control write and over the tick; when both writes hit
  // this channel together, the freshly written mode decides the load's out level.
  always_comb begin
    count_nx = count;
    out_nx   = out;
    eff_mode = cfg_we ? cfg_mode : mode;
    if (load) begin
      count_nx = data;
      out_nx   = (eff_mode == SQUARE);
    end else if (cfg_we) begin
      out_nx = 1'b0;
    end else if (en) begin
      case (mode)
        ONESHOT: begin
          if (count != '0) count_nx = count - 32'd1;
          else             out_nx   = 1'b1;
        end
        RATE: begin
          if (count <= 32'd1) begin
            count_nx = reload;
            out_nx   = 1'b1;
          end else begin
            count_nx = count - 32'd1;
            out_nx   = 1'b0;
          end
        end
        SQUARE: begin
          if (count <= 32'd1) begin
            count_nx = reload;
            out_nx   = ~out;
          end else begin
            count_nx = count - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
      mode   <= ONESHOT;
      en     <= 1'b0;
      out    <= 1'b0;
    end else begin
      count <= count_nx;
      out   <= out_nx;
      if (load) reload <= data;
      if (cfg_we) begin
        mode <= cfg_mode;
        en   <= cfg_en;
      end
    end
  end

endmodule

// File: rtl/bus_timer3.sv
// Three-channel bus timer: control-register decode, channel select and
// zero-latency read mux over three timer_channel instances.
module bus_timer3
  import bus_timer3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        counter_we,
  input  logic        ctrl_we,
  input  logic [31:0] Peripheral_in,
  output logic [31:0] counter_out,
  output logic        counter0_out,
  output logic        counter1_out,
  output logic        counter2_out
);

  logic [1:0]  sel;
  logic [1:0]  new_sel;
  logic        ctrl_ok;
  mode_e       new_mode;
  logic        new_en;
  logic [31:0] counts [NUM_CH];
  logic [NUM_CH-1:0] outs;

  assign new_sel  = Peripheral_in[SEL_MSB:SEL_LSB];
  assign new_mode = mode_e'(Peripheral_in[MODE_MSB:MODE_LSB]);
  assign new_en   = Peripheral_in[EN_BIT];
  assign ctrl_ok  = ctrl_we && (new_sel != 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sel <= '0;
    else if (ctrl_ok) sel <= new_sel;
  end

  // Loads address the pre-write sel; control writes address the new sel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel u_ch (
      .clk      (clk),
      .rst      (rst),
      .load     (counter_we && (sel == 2'(i))),
      .data     (Peripheral_in),
      .cfg_we   (ctrl_ok && (new_sel == 2'(i))),
      .cfg_mode (new_mode),
      .cfg_en   (new_en),
      .count    (counts[i]),
      .out      (outs[i])
    );
  end

  always_comb begin
    counter_out = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel == 2'(i)) counter_out = counts[i];
    end
  end

  assign counter0_out = outs[0];
  assign counter1_out = outs[1];
  assign counter2_out = outs[2];

endmodule

// File: tb/tb_bus_timer3.sv
// Directed bench for bus_timer3: a vector table covering the three modes and
// simultaneous writes, plus hand sequences for reset, hold and rate-reload-1.
module tb_bus_timer3;

  logic        clk = 1'b0;
  logic        rst;
  logic        counter_we;
  logic        ctrl_we;
  logic [31:0] Peripheral_in;
  logic [31:0] counter_out;
  logic        counter0_out;
  logic        counter1_out;
  logic        counter2_out;

  int total = 0;
  int bad   = 0;

  bus_timer3 dut (
    .clk           (clk),
    .rst           (rst),
    .counter_we    (counter_we),
    .ctrl_we       (ctrl_we),
    .Peripheral_in (Peripheral_in),
    .counter_out   (counter_out),
    .counter0_out  (counter0_out),
    .counter1_out  (counter1_out),
    .counter2_out  (counter2_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cw;
    logic        kw;
    logic [31:0] data;
    logic [31:0] exp_co;
    logic [2:0]  exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cw, input logic kw, input logic [31:0] data,
                     input logic [31:0] exp_co, input logic [2:0] exp_out);
    vec_t v;
    v.cw = cw; v.kw = kw; v.data = data; v.exp_co = exp_co; v.exp_out = exp_out;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] outs();
    return {counter2_out, counter1_out, counter0_out};
  endfunction

  task automatic step(input logic cw, input logic kw, input logic [31:0] data);
    @(negedge clk);
    ctrl_we = cw; counter_we = kw; Peripheral_in = data;
    @(posedge clk);
    #1;
    ctrl_we = 1'b0; counter_we = 1'b0; Peripheral_in = '0;
  endtask

  initial begin
    // Scenario 1: ch0 one-shot, load 3
    add(1, 0, 32'h10, 0, 3'b000);
    add(0, 1, 32'd3,  3, 3'b000);
    add(0, 0, 0, 2, 3'b000);
    add(0, 0, 0, 1, 3'b000);
    add(0, 0, 0, 0, 3'b000);
    add(0, 0, 0, 0, 3'b001);
    add(0, 0, 0, 0, 3'b001);
    // Scenario 2: ch1 rate, load 4
    add(1, 0, 32'h15, 0, 3'b001);
    add(0, 1, 32'd4,  4, 3'b001);
    add(0, 0, 0, 3, 3'b001);
    add(0, 0, 0, 2, 3'b001);
    add(0, 0, 0, 1, 3'b001);
    add(0, 0, 0, 4, 3'b011);
    add(0, 0, 0, 3, 3'b001);
    add(0, 0, 0, 2, 3'b001);
    add(0, 0, 0, 1, 3'b001);
    add(0, 0, 0, 4, 3'b011);
    // Scenario 3: ch2 square, load 2
    add(1, 0, 32'h1A, 0, 3'b001);
    add(0, 1, 32'd2,  2, 3'b101);
    add(0, 0, 0, 1, 3'b101);
    add(0, 0, 0, 2, 3'b011);
    add(0, 0, 0, 1, 3'b001);
    add(0, 0, 0, 2, 3'b101);
    add(0, 0, 0, 1, 3'b101);
    // Scenario 4: back to sel 0, then simultaneous load + ctrl 0x11
    add(1, 0, 32'h00, 0, 3'b010);
    add(1, 1, 32'h11, 4, 3'b000);
    add(0, 0, 0, 3, 3'b100);
    add(1, 0, 32'h00, 32'h11, 3'b100);
    // Scenario 5: sel field 3 is ignored
    add(1, 0, 32'h03, 32'h11, 3'b000);

    rst = 1'b1; ctrl_we = 1'b0; counter_we = 1'b0; Peripheral_in = '0;
    #2;
    check("reset_count", counter_out, 32'd0);
    check("reset_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].cw, vecs[i].kw, vecs[i].data);
      check($sformatf("vec%0d_count", i), counter_out, vecs[i].exp_co);
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_out));
    end

    // Reset mid-count: ch0 down to 5, ch1 one-shot already fired
    step(1, 0, 32'h10);
    step(0, 1, 32'd7);
    step(0, 0, 0);
    step(0, 0, 0);
    check("pre_reset_count", counter_out, 32'd5);
    check("pre_reset_outs", 32'(outs()), 32'b010);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_count", counter_out, 32'd0);
    check("async_reset_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("idle_after_reset_count", counter_out, 32'd0);
    check("idle_after_reset_outs", 32'(outs()), 32'd0);

    // Hold mode: enabled but frozen
    step(1, 0, 32'h1C);
    step(0, 1, 32'd5);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("hold_count", counter_out, 32'd5);
    check("hold_outs", 32'(outs()), 32'd0);

    // Rate mode with reload 1 keeps the output high
    step(1, 0, 32'h15);
    step(0, 1, 32'd1);
    check("rate1_load_outs", 32'(outs()), 32'b000);
    step(0, 0, 0);
    check("rate1_tick1_outs", 32'(outs()), 32'b010);
    check("rate1_tick1_count", counter_out, 32'd1);
    step(0, 0, 0);
    check("rate1_tick2_outs", 32'(outs()), 32'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
